text_ram_arbiter: RTL

- Shares the single-port text RAM (1-cycle synchronous read) between three requesters: the video text fetcher, a host write/read port, and an internal screen-fill engine.
- Priority: video > fill > host. Video reads are never stalled.
- Sits between videotext, a future CPU bus bridge and text_ram, replacing the hard-wired video→RAM connection.

---
 rtl/text_pkg.sv | 7 +
 rtl/text_fill_seq.sv | 57 +++++
 rtl/text_ram_arbiter.sv | 71 +++++++
 3 files changed

// File: rtl/text_pkg.sv
// text_pkg: shared widths and enums for the text RAM arbiter
package text_pkg;
    localparam int AW = 10;
    localparam int DW = 8;
    typedef enum logic [1:0] {OWN_NONE, OWN_VIDEO, OWN_HOST} owner_t;
    typedef enum logic {ST_IDLE, ST_FILL} fill_state_t;
endpackage

// File: rtl/text_fill_seq.sv
// text_fill_seq: walks every RAM cell once writing a latched fill byte
// Ports: i_start pulse begins a fill (ignored while busy), i_stall holds the counter,
// i_value is the fill byte; o_write/o_cnt/o_value drive the RAM write, o_busy/o_done report status.
module text_fill_seq
    import text_pkg::*;
#(
    parameter int AW = text_pkg::AW,
    parameter int DW = text_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic          i_stall,
    input  logic [DW-1:0] i_value,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_write,
    output logic [AW-1:0] o_cnt,
    output logic [DW-1:0] o_value
);
    fill_state_t   r_state, w_next;
    logic [AW-1:0] r_cnt, w_cnt;
    logic [DW-1:0] r_value;
    logic          r_done;
    logic          w_write, w_last;

    assign w_write = (r_state == ST_FILL) && !i_stall;
    assign w_last  = w_write && (r_cnt == '1);

    // The counter wraps to zero on the last write, so it is already zero when a new fill starts.
    always_comb begin
        w_next = r_state;
        w_cnt  = w_write ? r_cnt + 1'b1 : r_cnt;
        w_next = (r_state == ST_IDLE) ? (i_start ? ST_FILL : ST_IDLE) : (w_last ? ST_IDLE : ST_FILL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_value <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_done  <= w_last;
            if (r_state == ST_IDLE && i_start)
                r_value <= i_value;
        end
    end

    assign o_busy  = (r_state == ST_FILL);
    assign o_done  = r_done;
    assign o_write = w_write;
    assign o_cnt   = r_cnt;
    assign o_value = r_value;
endmodule

// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter: shares the single-port text RAM between video, fill engine and host
// Ports: v_* video read (never stalled), h_* host handshake (held until h_ack),
// fill_* screen-fill control/status, ram_* to/from the 1-cycle synchronous text RAM.
module text_ram_arbiter
    import text_pkg::*;
#(
    parameter int AW = text_pkg::AW,
    parameter int DW = text_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          v_req,
    input  logic [AW-1:0] v_addr,
    output logic          v_valid,
    output logic [DW-1:0] v_data,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_ack,
    output logic [DW-1:0] h_rdata,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_value,
    output logic          fill_busy,
    output logic          fill_done,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    owner_t        r_own, w_own;
    logic          w_h_grant, w_fill_we;
    logic [AW-1:0] w_fill_addr;
    logic [DW-1:0] w_fill_din;

    text_fill_seq #(.AW(AW), .DW(DW)) u_fill (
        .clk     (clk),
        .reset   (reset),
        .i_start (fill_start),
        .i_stall (v_req),
        .i_value (fill_value),
        .o_busy  (fill_busy),
        .o_done  (fill_done),
        .o_write (w_fill_we),
        .o_cnt   (w_fill_addr),
        .o_value (w_fill_din)
    );

    // The ack cycle is excluded so a still-asserted h_req is not granted twice.
    assign w_h_grant = h_req & ~v_req & ~fill_busy & ~h_ack;

    // Writes are suppressed during reset so an aborted fill leaves the current cell untouched.
    always_comb begin
        w_own    = v_req ? OWN_VIDEO : (w_h_grant ? OWN_HOST : OWN_NONE);
        ram_we   = ~reset & (w_fill_we | (w_h_grant & h_we));
        ram_addr = v_req ? v_addr : (w_fill_we ? w_fill_addr : h_addr);
        ram_din  = w_fill_we ? w_fill_din : h_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_own <= OWN_NONE;
        else
            r_own <= w_own;
    end

    assign v_valid = (r_own == OWN_VIDEO);
    assign h_ack   = (r_own == OWN_HOST);
    assign v_data  = ram_dout;
    assign h_rdata = ram_dout;
endmodule
